// File: rtl/ysyx_040978_lut_arbiter.sv
// Round-robin arbiter sharing one programmable key->data lookup table between NR_REQ requesters.
// Optional hit/miss counters: define YSYX_040978_LUT_ARB_STATS_EN.
module ysyx_040978_lut_arbiter #(
  parameter int NR_REQ      = 4,
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 8,
  parameter int DATA_LEN    = 32,
  parameter int HAS_DEFAULT = 1,
  localparam int ID_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1,
  localparam int IDX_W = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NR_REQ-1:0]         req_valid,
  input  logic [NR_REQ*KEY_LEN-1:0] req_key,
  output logic [NR_REQ-1:0]         req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_LEN-1:0]       resp_data,
  output logic                      resp_hit,
  input  logic                      cfg_we,
  input  logic [IDX_W-1:0]          cfg_idx,
  input  logic [KEY_LEN-1:0]        cfg_key,
  input  logic [DATA_LEN-1:0]       cfg_data,
  input  logic                      cfg_clr,
  input  logic                      cfg_def_we,
  input  logic [DATA_LEN-1:0]       cfg_default,
  output logic                      busy
`ifdef YSYX_040978_LUT_ARB_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [31:0]               hit_cnt,
  output logic [31:0]               miss_cnt
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]          state;
  logic [ID_W-1:0]     last;
  logic [KEY_LEN-1:0]  key_p0;
  logic [ID_W-1:0]     id_p0;
  logic [NR_KEY-1:0]   ent_vld;
  logic [KEY_LEN-1:0]  ent_key  [NR_KEY];
  logic [DATA_LEN-1:0] ent_data [NR_KEY];
  logic [DATA_LEN-1:0] def_data;
  logic                grant_found;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W-1:0]     cand;
  logic                match_hit;
  logic [DATA_LEN-1:0] match_data;
  logic                accept;

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign accept     = resp_valid & resp_ready;

  // scan from the requester after the last winner, wrapping around
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 1; i <= NR_REQ; i++) begin
      cand = ID_W'((int'(last) + i) % NR_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !reset && grant_found) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    match_hit  = 1'b0;
    match_data = '0;
    for (int e = 0; e < NR_KEY; e++) begin
      if (ent_vld[e] && ent_key[e] == key_p0) begin
        match_hit  = 1'b1;
        match_data = match_data | ent_data[e];
      end
    end
    if (!match_hit) match_data = (HAS_DEFAULT != 0) ? def_data : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      last      <= ID_W'(NR_REQ - 1);
      resp_id   <= '0;
      resp_data <= '0;
      resp_hit  <= 1'b0;
      ent_vld   <= '0;
      def_data  <= '0;
    end else begin
      case (state)
        IDLE:    if (grant_found) state <= LOOKUP;
        LOOKUP: begin
          resp_data <= match_data;
          resp_hit  <= match_hit;
          resp_id   <= id_p0;
          state     <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            last  <= resp_id;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      for (int e = 0; e < NR_KEY; e++) begin
        if (cfg_idx == IDX_W'(e)) begin
          if (cfg_clr)     ent_vld[e] <= 1'b0;
          else if (cfg_we) ent_vld[e] <= 1'b1;
        end
      end
      if (cfg_def_we) def_data <= cfg_default;
    end
  end

  // stage p0: latched request and table payload, no reset needed
  always_ff @(posedge clock) begin
    if (state == IDLE && grant_found) begin
      key_p0 <= req_key[int'(grant_id)*KEY_LEN +: KEY_LEN];
      id_p0  <= grant_id;
    end
    for (int e = 0; e < NR_KEY; e++) begin
      if (cfg_we && !cfg_clr && cfg_idx == IDX_W'(e)) begin
        ent_key[e]  <= cfg_key;
        ent_data[e] <= cfg_data;
      end
    end
  end

`ifdef YSYX_040978_LUT_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset || stats_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (resp_hit) hit_cnt  <= hit_cnt + 32'd1;
      else          miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_040978_lut_arbiter.sv
// Self-checking bench for ysyx_040978_lut_arbiter: transaction-level model plus directed literal checks.
module tb_ysyx_040978_lut_arbiter;
  localparam int NR_REQ = 4, NR_KEY = 4, KEY_LEN = 8, DATA_LEN = 32, HAS_DEFAULT = 1;
  localparam int ID_W = 2, IDX_W = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NR_REQ-1:0]         req_valid = '0;
  logic [NR_REQ*KEY_LEN-1:0] req_key = '0;
  logic [NR_REQ-1:0]         req_ready;
  logic                      resp_valid;
  logic                      resp_ready = 1'b0;
  logic [ID_W-1:0]           resp_id;
  logic [DATA_LEN-1:0]       resp_data;
  logic                      resp_hit;
  logic                      cfg_we = 1'b0;
  logic [IDX_W-1:0]          cfg_idx = '0;
  logic [KEY_LEN-1:0]        cfg_key = '0;
  logic [DATA_LEN-1:0]       cfg_data = '0;
  logic                      cfg_clr = 1'b0;
  logic                      cfg_def_we = 1'b0;
  logic [DATA_LEN-1:0]       cfg_default = '0;
  logic                      busy;
`ifdef YSYX_040978_LUT_ARB_STATS_EN
  logic                      stats_clr = 1'b0;
  logic [31:0]               hit_cnt, miss_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  ysyx_040978_lut_arbiter dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_hit(resp_hit),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key), .cfg_data(cfg_data),
    .cfg_clr(cfg_clr), .cfg_def_we(cfg_def_we), .cfg_default(cfg_default),
    .busy(busy)
`ifdef YSYX_040978_LUT_ARB_STATS_EN
    , .stats_clr(stats_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_age counts cycles since a grant: 0 none, 1 lookup pending, 2 response offered
  int                  m_age = 0;
  int                  m_last = NR_REQ - 1;
  int                  m_pid = 0;
  logic [KEY_LEN-1:0]  m_pkey = '0;
  logic [NR_KEY-1:0]   m_val = '0;
  logic [KEY_LEN-1:0]  m_key  [NR_KEY];
  logic [DATA_LEN-1:0] m_data [NR_KEY];
  logic [DATA_LEN-1:0] m_def = '0;
  logic [ID_W-1:0]     m_rid = '0;
  logic [DATA_LEN-1:0] m_rdata = '0;
  logic                m_rhit = 1'b0;
  logic [31:0]         m_hc = '0, m_mc = '0;

  function automatic int pick(input logic [NR_REQ-1:0] v, input int lst);
    for (int i = 1; i <= NR_REQ; i++)
      if (v[(lst + i) % NR_REQ]) return (lst + i) % NR_REQ;
    return -1;
  endfunction

  always @(negedge clock) begin
    int g;
    logic [NR_REQ-1:0] er;
    logic lh;
    logic [DATA_LEN-1:0] ld;
    logic sclr;
    er = '0;
    g = -1;
    if (!reset && m_age == 0) begin
      g = pick(req_valid, m_last);
      if (g >= 0) er[g] = 1'b1;
    end
    chk("req_ready", req_ready, er);
    chk("resp_valid", resp_valid, m_age == 2);
    chk("busy", busy, m_age != 0);
    chk("resp_id", resp_id, m_rid);
    chk("resp_data", resp_data, m_rdata);
    chk("resp_hit", resp_hit, m_rhit);
    sclr = 1'b0;
`ifdef YSYX_040978_LUT_ARB_STATS_EN
    chk("hit_cnt", hit_cnt, m_hc);
    chk("miss_cnt", miss_cnt, m_mc);
    sclr = stats_clr;
`endif
    if (reset) begin
      m_age = 0; m_last = NR_REQ - 1; m_val = '0; m_def = '0;
      m_rid = '0; m_rdata = '0; m_rhit = 1'b0; m_hc = '0; m_mc = '0;
    end else begin
      if (m_age == 0) begin
        if (g >= 0) begin
          m_pid = g;
          m_pkey = req_key[g*KEY_LEN +: KEY_LEN];
          m_age = 1;
        end
      end else if (m_age == 1) begin
        lh = 1'b0; ld = '0;
        for (int e = 0; e < NR_KEY; e++)
          if (m_val[e] && m_key[e] == m_pkey) begin lh = 1'b1; ld = ld | m_data[e]; end
        if (!lh) ld = (HAS_DEFAULT != 0) ? m_def : '0;
        m_rid = ID_W'(m_pid); m_rdata = ld; m_rhit = lh; m_age = 2;
      end else if (resp_ready) begin
        m_last = m_rid;
        m_age = 0;
        if (!sclr) begin
          if (m_rhit) m_hc = m_hc + 1;
          else        m_mc = m_mc + 1;
        end
      end
      if (sclr) begin m_hc = '0; m_mc = '0; end
      if (cfg_clr) m_val[cfg_idx] = 1'b0;
      else if (cfg_we) begin
        m_val[cfg_idx] = 1'b1; m_key[cfg_idx] = cfg_key; m_data[cfg_idx] = cfg_data;
      end
      if (cfg_def_we) m_def = cfg_default;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    step(); reset = 1'b1;
    step(); reset = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input logic [KEY_LEN-1:0] k, input logic [DATA_LEN-1:0] d);
    step(); cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_key = k; cfg_data = d;
    step(); cfg_we = 1'b0;
  endtask

  task automatic do_req(input logic [NR_REQ-1:0] mask, input logic [KEY_LEN-1:0] key,
                        output logic [NR_REQ-1:0] rdy, output logic [ID_W-1:0] id,
                        output logic [DATA_LEN-1:0] d, output logic h);
    step();
    for (int n = 0; n < NR_REQ; n++) if (mask[n]) req_key[n*KEY_LEN +: KEY_LEN] = key;
    req_valid = mask; resp_ready = 1'b1;
    #1 rdy = req_ready;
    step(); req_valid = '0;
    #1 chk("lat_busy", busy, 1'b1);
    chk("lat_no_resp_yet", resp_valid, 1'b0);
    step();
    #1 chk("lat_resp", resp_valid, 1'b1);
    id = resp_id; d = resp_data; h = resp_hit;
    step();
  endtask

  logic [NR_REQ-1:0]   rdy;
  logic [ID_W-1:0]     id;
  logic [DATA_LEN-1:0] d, d0;
  logic                h;
  int                  grants[5];
  int                  ng;

  initial begin
    do_reset();
    #1 chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_data", resp_data, 32'h0);

    // basic hit then miss with default
    cfg_write(0, 8'h12, 32'hDEADBEEF);
    do_req(4'b0100, 8'h12, rdy, id, d, h);
    chk("hit_ready", rdy, 4'b0100);
    chk("hit_id", id, 2);
    chk("hit_data", d, 32'hDEADBEEF);
    chk("hit_flag", h, 1'b1);
    step(); cfg_def_we = 1'b1; cfg_default = 32'h55;
    step(); cfg_def_we = 1'b0;
    do_req(4'b0100, 8'h34, rdy, id, d, h);
    chk("miss_data", d, 32'h55);
    chk("miss_flag", h, 1'b0);

    // round robin from reset
    do_reset();
    req_key = {8'h01, 8'h02, 8'h03, 8'h04};
    req_valid = 4'hF; resp_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      #1;
      if (req_ready != '0) begin
        chk("rr_onehot", $onehot(req_ready), 1'b1);
        for (int n = 0; n < NR_REQ; n++) if (req_ready[n]) grants[ng] = n;
        ng++;
        if (ng == 5) req_valid = '0;
      end
      step();
    end
    chk("rr_count", ng, 5);
    chk("rr_g0", grants[0], 0);
    chk("rr_g1", grants[1], 1);
    chk("rr_g2", grants[2], 2);
    chk("rr_g3", grants[3], 3);
    chk("rr_g4", grants[4], 0);
    req_valid = '0;
    repeat (4) step();

    // back-pressure (default still 0 after reset, set it again)
    step(); cfg_def_we = 1'b1; cfg_default = 32'h55;
    step(); cfg_def_we = 1'b0;
    req_key[1*KEY_LEN +: KEY_LEN] = 8'h34; req_valid = 4'b0010; resp_ready = 1'b0;
    step(); req_valid = 4'hF;
    step();
    #1 d0 = resp_data;
    chk("bp_data", d0, 32'h55);
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", resp_valid, 1'b1);
      chk("bp_stable", resp_data, d0);
      chk("bp_ready", req_ready, 4'b0000);
      chk("bp_busy", busy, 1'b1);
      step(); #1;
    end
    resp_ready = 1'b1; req_valid = '0;
    step();
    #1 chk("bp_idle", busy, 1'b0);
    chk("bp_drop", resp_valid, 1'b0);

    // config write during lookup uses the old table
    cfg_write(0, 8'h12, 32'h7);
    step(); req_key[3*KEY_LEN +: KEY_LEN] = 8'h12; req_valid = 4'b1000; resp_ready = 1'b1;
    step(); req_valid = '0; cfg_we = 1'b1; cfg_idx = 0; cfg_key = 8'h12; cfg_data = 32'h1;
    step(); cfg_we = 1'b0;
    #1 chk("race_old", resp_data, 32'h7);
    step();
    do_req(4'b1000, 8'h12, rdy, id, d, h);
    chk("race_new", d, 32'h1);
    step(); cfg_we = 1'b1; cfg_clr = 1'b1; cfg_idx = 0; cfg_data = 32'h2;
    step(); cfg_we = 1'b0; cfg_clr = 1'b0;
    do_req(4'b0001, 8'h12, rdy, id, d, h);
    chk("clr_wins_hit", h, 1'b0);
    chk("clr_wins_data", d, 32'h55);

    // reset while a response is offered
    cfg_write(1, 8'h22, 32'hAB);
    step(); req_key[3*KEY_LEN +: KEY_LEN] = 8'h22; req_valid = 4'b1000; resp_ready = 1'b0;
    step(); req_valid = '0;
    step();
    #1 chk("rr_pre_valid", resp_valid, 1'b1);
    chk("rr_pre_data", resp_data, 32'hAB);
    reset = 1'b1;
    step(); reset = 1'b0;
    #1 chk("rst_mid_valid", resp_valid, 1'b0);
    do_req(4'hF, 8'h22, rdy, id, d, h);
    chk("rst_mid_grant", rdy, 4'b0001);
    chk("rst_mid_id", id, 0);
    chk("rst_mid_data", d, 32'h0);
    chk("rst_mid_hit", h, 1'b0);

`ifdef YSYX_040978_LUT_ARB_STATS_EN
    step(); stats_clr = 1'b1;
    step(); stats_clr = 1'b0;
    cfg_write(2, 8'h40, 32'h9);
    for (int i = 0; i < 3; i++) do_req(4'b0010, 8'h40, rdy, id, d, h);
    for (int i = 0; i < 2; i++) do_req(4'b0010, 8'h41, rdy, id, d, h);
    #1 chk("stat_hits", hit_cnt, 32'd3);
    chk("stat_misses", miss_cnt, 32'd2);
    step(); stats_clr = 1'b1;
    step(); stats_clr = 1'b0;
    #1 chk("stat_clr_hit", hit_cnt, 32'd0);
    chk("stat_clr_miss", miss_cnt, 32'd0);
`endif

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int n = 0; n < NR_REQ; n++) begin
        if (!req_valid[n]) req_key[n*KEY_LEN +: KEY_LEN] = 8'h10 + 8'($urandom_range(0, 7));
        req_valid[n] = ($urandom_range(0, 3) == 0);
      end
      resp_ready  = ($urandom_range(0, 9) < 7);
      cfg_we      = ($urandom_range(0, 7) < 2);
      cfg_clr     = ($urandom_range(0, 9) == 0);
      cfg_idx     = IDX_W'($urandom_range(0, NR_KEY - 1));
      cfg_key     = 8'h10 + 8'($urandom_range(0, 7));
      cfg_data    = $urandom;
      cfg_def_we  = ($urandom_range(0, 9) == 0);
      cfg_default = $urandom;
      reset       = ($urandom_range(0, 199) == 0);
`ifdef YSYX_040978_LUT_ARB_STATS_EN
      stats_clr   = ($urandom_range(0, 99) == 0);
`endif
    end
    step();
    req_valid = '0; resp_ready = 1'b1; cfg_we = 1'b0; cfg_clr = 1'b0; cfg_def_we = 1'b0; reset = 1'b0;
`ifdef YSYX_040978_LUT_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (6) step();
    #1 chk("final_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
